// File: rtl/jtkicker_gfxarb_if.sv
// Simple read port: requester drives cs/addr, responder returns data/ok.
// Used for the scroll, object and shared SDRAM ports of the graphics arbiter.
interface jtkicker_gfxarb_if #(
    parameter int AW = 13
);
    logic          cs;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          ok;

    modport master (output cs, addr, input data, ok);
    modport slave  (input cs, addr, output data, ok);
endinterface

// File: rtl/jtkicker_gfxarb.sv
// Shares one graphics-ROM read port between the scroll and object fetchers.
// One-word hit cache per requester, scroll priority with object anti-starvation.
module jtkicker_gfxarb #(
    parameter int                SCR_AW     = 13,
    parameter int                OBJ_AW     = 14,
    parameter int                ROM_AW     = 15,
    parameter logic [ROM_AW-1:0] OBJ_OFFSET = 15'h2000,
    parameter int                STARVE     = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    jtkicker_gfxarb_if.slave  scr,
    jtkicker_gfxarb_if.slave  obj,
    jtkicker_gfxarb_if.master rom
);
    localparam int CW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              sel;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [CW-1:0]     starve_cnt;

    logic [SCR_AW-1:0] scr_tag;
    logic              scr_valid;
    logic [31:0]       scr_buf;
    logic [OBJ_AW-1:0] obj_tag;
    logic              obj_valid;
    logic [31:0]       obj_buf;

    logic              scr_hit, obj_hit, scr_pend, obj_pend;
    logic              obj_win, grant;
    logic [ROM_AW-1:0] scr_rom, obj_rom;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        scr_hit  = scr.cs && scr_valid && (scr_tag == scr.addr);
        obj_hit  = obj.cs && obj_valid && (obj_tag == obj.addr);
        scr_pend = scr.cs && !scr_hit;
        obj_pend = obj.cs && !obj_hit;
        obj_win  = obj_pend && (!scr_pend || starve_cnt >= CW'(STARVE));
        grant    = (state == IDLE) && (scr_pend || obj_pend);
        scr_rom  = ROM_AW'(scr.addr);
        obj_rom  = ROM_AW'(obj.addr) + OBJ_OFFSET;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Reset lands in IDLE, so a leftover rom_ok is ignored just as in GAP.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant)  state_nx = BUSY;
            BUSY:    if (rom.ok) state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rom.cs   = (state == BUSY);
        rom.addr = rom_addr_q;
        scr.ok   = scr_hit;
        scr.data = scr_buf;
        obj.ok   = obj_hit;
        obj.data = obj_buf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            rom_addr_q <= '0;
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant) begin
                sel        <= obj_win;
                rom_addr_q <= obj_win ? obj_rom : scr_rom;
            end
            if (!obj_pend || obj_win)
                starve_cnt <= '0;
            else if (grant && starve_cnt != '1)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // NOTE: the cache words are plain registers, so they are reset like any
    // other state; the data outputs must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_tag   <= '0;
            scr_valid <= 1'b0;
            scr_buf   <= '0;
            obj_tag   <= '0;
            obj_valid <= 1'b0;
            obj_buf   <= '0;
        end else if (state == BUSY && rom.ok) begin
            // Tags come from the latched port address, not the live request.
            if (sel) begin
                obj_tag   <= OBJ_AW'(rom_addr_q - OBJ_OFFSET);
                obj_valid <= 1'b1;
                obj_buf   <= rom.data;
            end else begin
                scr_tag   <= SCR_AW'(rom_addr_q);
                scr_valid <= 1'b1;
                scr_buf   <= rom.data;
            end
        end
    end
endmodule

// File: tb/tb_jtkicker_gfxarb.sv
// Directed bench for jtkicker_gfxarb with a hand-driven SDRAM port.
module tb_jtkicker_gfxarb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtkicker_gfxarb_if #(.AW(13)) scr_bus ();
    jtkicker_gfxarb_if #(.AW(14)) obj_bus ();
    jtkicker_gfxarb_if #(.AW(15)) rom_bus ();

    jtkicker_gfxarb #(
        .SCR_AW(13), .OBJ_AW(14), .ROM_AW(15), .OBJ_OFFSET(15'h2000), .STARVE(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .scr   (scr_bus),
        .obj   (obj_bus),
        .rom   (rom_bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (rom_bus.cs !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check(tag, rom_bus.cs, 1);
    endtask

    task automatic serve(input logic [31:0] d, input int delay);
        repeat (delay) tick();
        rom_bus.data = d;
        rom_bus.ok   = 1'b1;
        tick();
        rom_bus.ok   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        seen;
        logic [12:0] scr_a;
        logic [14:0] exp_addr;
        logic [7:0]  cs_exp, sok_exp, ook_exp;

        scr_bus.cs = 1'b1; scr_bus.addr = '0;
        obj_bus.cs = 1'b1; obj_bus.addr = '0;
        rom_bus.ok = 1'b0; rom_bus.data = '0;

        // Reset with both requesters active
        repeat (3) tick();
        check("rst_rom_cs",   rom_bus.cs,   0);
        check("rst_rom_addr", rom_bus.addr, 0);
        check("rst_scr_ok",   scr_bus.ok,   0);
        check("rst_obj_ok",   obj_bus.ok,   0);
        check("rst_scr_data", scr_bus.data, 0);
        check("rst_obj_data", obj_bus.data, 0);

        obj_bus.cs   = 1'b0;
        scr_bus.addr = 13'h0005;
        rst_n        = 1'b1;
        tick();
        check("first_rom_cs",   rom_bus.cs,   1);
        check("first_rom_addr", rom_bus.addr, 15'h0005);

        // Scroll miss, answered after a few wait cycles
        repeat (3) tick();
        check("busy_hold_cs",   rom_bus.cs,   1);
        check("busy_hold_addr", rom_bus.addr, 15'h0005);
        check("busy_scr_ok",    scr_bus.ok,   0);
        serve(32'hDEADBEEF, 0);
        check("miss_scr_ok",   scr_bus.ok,   1);
        check("miss_scr_data", scr_bus.data, 32'hDEADBEEF);
        check("gap_rom_cs",    rom_bus.cs,   0);

        // Hit is combinational on the address
        scr_bus.addr = 13'h0006; #1;
        check("hit_drop", scr_bus.ok, 0);
        scr_bus.addr = 13'h0005; #1;
        check("hit_back", scr_bus.ok, 1);
        scr_bus.cs = 1'b0;
        tick();
        scr_bus.cs = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen |= rom_bus.cs;
        end
        check("hit_no_fetch", seen, 0);

        // Object offset
        scr_bus.cs   = 1'b0;
        obj_bus.cs   = 1'b1;
        obj_bus.addr = 14'h0010;
        wait_grant("obj_grant");
        check("obj_rom_addr", rom_bus.addr, 15'h2010);
        check("obj_busy_ok",  obj_bus.ok,   0);
        serve(32'h12345678, 1);
        check("obj_ok",   obj_bus.ok,   1);
        check("obj_data", obj_bus.data, 32'h12345678);

        // Priority and starvation: 8 scroll grants, then object, then scroll again
        scr_bus.cs   = 1'b1;
        obj_bus.addr = 14'h0200;
        scr_a        = 13'h0100;
        for (int i = 0; i < 10; i++) begin
            scr_bus.addr = scr_a;
            wait_grant($sformatf("starve_grant%0d", i));
            exp_addr = (i == 8) ? 15'h2200 : {2'b00, scr_a};
            check($sformatf("starve_addr%0d", i), rom_bus.addr, exp_addr);
            serve(32'h1000 + 32'(i), 0);
            if (i == 8) begin
                check("starve_obj_ok", obj_bus.ok, 1);
                obj_bus.addr = 14'h0201;
            end else begin
                check($sformatf("starve_scr_ok%0d", i), scr_bus.ok, 1);
                scr_a = scr_a + 13'd1;
            end
        end
        obj_bus.cs = 1'b0;

        // Address change while BUSY
        scr_bus.addr = 13'h0300;
        wait_grant("chg_grant");
        check("chg_addr0", rom_bus.addr, 15'h0300);
        tick();
        scr_bus.addr = 13'h0301;
        serve(32'hAAAA5555, 1);
        check("chg_gap_cs", rom_bus.cs, 0);
        check("chg_new_ok", scr_bus.ok, 0);
        scr_bus.addr = 13'h0300; #1;
        check("chg_old_ok",   scr_bus.ok,   1);
        check("chg_old_data", scr_bus.data, 32'hAAAA5555);
        scr_bus.addr = 13'h0301; #1;
        wait_grant("chg_grant2");
        check("chg_addr1", rom_bus.addr, 15'h0301);
        serve(32'h5555AAAA, 0);
        check("chg_new_data", scr_bus.data, 32'h5555AAAA);

        // rom_ok held high: GAP still separates accesses
        scr_bus.addr = 13'h0400;
        obj_bus.cs   = 1'b1;
        obj_bus.addr = 14'h0500;
        rom_bus.ok   = 1'b1;
        cs_exp  = 8'b0001_0010;
        sok_exp = 8'b1111_1100;
        ook_exp = 8'b1110_0000;
        for (int k = 0; k < 8; k++) begin
            rom_bus.data = 32'hCAFE0000 + 32'(k);
            tick();
            check($sformatf("stale_cs%0d", k),  rom_bus.cs, cs_exp[k]);
            check($sformatf("stale_sok%0d", k), scr_bus.ok, sok_exp[k]);
            check($sformatf("stale_ook%0d", k), obj_bus.ok, ook_exp[k]);
            if (k == 1) check("stale_scr_addr", rom_bus.addr, 15'h0400);
            if (k == 4) check("stale_obj_addr", rom_bus.addr, 15'h2500);
        end
        check("stale_scr_data", scr_bus.data, 32'hCAFE0002);
        check("stale_obj_data", obj_bus.data, 32'hCAFE0005);
        rom_bus.ok = 1'b0;

        // Asynchronous reset in the middle of an access
        obj_bus.cs   = 1'b0;
        scr_bus.addr = 13'h0600;
        wait_grant("rst_mid_grant");
        scr_bus.addr = 13'h0400;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_cs",   rom_bus.cs,   0);
        check("rst_mid_addr", rom_bus.addr, 0);
        check("rst_mid_ok",   scr_bus.ok,   0);
        check("rst_mid_data", scr_bus.data, 0);
        rom_bus.ok   = 1'b1;
        rom_bus.data = 32'h0BADF00D;
        scr_bus.addr = 13'h0600;
        #2 rst_n = 1'b1;
        tick();
        check("rst_rel_cs", rom_bus.cs, 1);
        check("rst_rel_ok", scr_bus.ok, 0);
        tick();
        rom_bus.ok = 1'b0;
        check("rst_rel_data", scr_bus.data, 32'h0BADF00D);
        check("rst_rel_gap",  rom_bus.cs,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
